// File: rtl/pe_au_seq.sv
// Operation sequencer in front of a PE DSP arithmetic unit: turns a stream of
// FIOS limb triples into latency-aligned A/B/C/OPMODE issues and collects P limbs.
module pe_au_seq #(
    parameter int ABREG = 1,
    parameter int MREG  = 1
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [16:0] in_a_i,
    input  logic [16:0] in_b_i,
    input  logic [16:0] in_t_i,
    input  logic        in_last_i,
    output logic [16:0] au_a_o,
    output logic [16:0] au_b_o,
    output logic [33:0] au_c_o,
    output logic        au_creg_en_o,
    output logic [8:0]  au_opmode_o,
    input  logic [33:0] au_p_i,
    output logic        out_valid_o,
    output logic [16:0] out_limb_o,
    output logic        out_last_o
);

    localparam int DSP_REG_LEVEL = 1 + ABREG + MREG;
    localparam int OPM_STAGE     = DSP_REG_LEVEL - 2;
    localparam int P_STAGE       = DSP_REG_LEVEL;

    generate
        if (ABREG + MREG < 1) begin : g_bad_cfg
            $error("pe_au_seq: ABREG+MREG must be at least 1");
        end
    endgenerate

    localparam logic [8:0] OPM_IDLE   = 9'h000;
    localparam logic [8:0] OPM_FIRST  = 9'h035;
    localparam logic [8:0] OPM_NEXT   = 9'h1D5;
    localparam logic [8:0] OPM_FLUSH  = 9'h050;
    localparam logic [8:0] OPM_BUBBLE = 9'h020;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_FLUSH
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_FIRST,
        OP_NEXT,
        OP_FLUSH,
        OP_BUBBLE
    } op_t;

    typedef struct packed {
        op_t         op;
        logic [16:0] t;
    } desc_t;

    state_t      state_q, state_d;
    logic [16:0] a_q, a_d;
    logic [16:0] b_q, b_d;
    desc_t       pipe_q [0:P_STAGE];
    desc_t       pipe_d [0:P_STAGE];
    desc_t       new_desc;
    desc_t       alu_desc;
    desc_t       p_desc;
    logic        out_valid_q, out_valid_d;
    logic [16:0] out_limb_q, out_limb_d;
    logic        out_last_q, out_last_d;
    logic        accept;
    logic        unused_p_hi;

    // Carry lives in the upper P bits inside the AU; only the low limb is taken here.
    assign unused_p_hi = ^au_p_i[33:17];

    assign in_ready_o = (state_q != S_FLUSH);
    assign accept     = in_valid_i & in_ready_o;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_BURST: begin
                if (accept) begin
                    state_d = in_last_i ? S_FLUSH : S_BURST;
                end
            end
            S_FLUSH: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // One op enters the pipe every cycle; gaps inside a word become P-hold bubbles.
    always_comb begin
        a_d         = '0;
        b_d         = '0;
        new_desc.op = OP_NONE;
        new_desc.t  = '0;
        if (accept) begin
            a_d         = in_a_i;
            b_d         = in_b_i;
            new_desc.op = (state_q == S_IDLE) ? OP_FIRST : OP_NEXT;
            new_desc.t  = in_t_i;
        end else if (state_q == S_FLUSH) begin
            new_desc.op = OP_FLUSH;
        end else if (state_q == S_BURST) begin
            new_desc.op = OP_BUBBLE;
        end
    end

    always_comb begin
        pipe_d[0] = new_desc;
        for (int i = 1; i <= P_STAGE; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    assign alu_desc = pipe_q[OPM_STAGE];
    assign p_desc   = pipe_q[P_STAGE];

    always_comb begin
        au_opmode_o  = OPM_IDLE;
        au_creg_en_o = 1'b0;
        au_c_o       = '0;
        case (alu_desc.op)
            OP_FIRST: begin
                au_opmode_o  = OPM_FIRST;
                au_creg_en_o = 1'b1;
                au_c_o       = {17'b0, alu_desc.t};
            end
            OP_NEXT: begin
                au_opmode_o  = OPM_NEXT;
                au_creg_en_o = 1'b1;
                au_c_o       = {17'b0, alu_desc.t};
            end
            OP_FLUSH:  au_opmode_o = OPM_FLUSH;
            OP_BUBBLE: au_opmode_o = OPM_BUBBLE;
            default:   au_opmode_o = OPM_IDLE;
        endcase
    end

    always_comb begin
        out_valid_d = (p_desc.op == OP_FIRST) || (p_desc.op == OP_NEXT) ||
                      (p_desc.op == OP_FLUSH);
        out_limb_d  = out_valid_d ? au_p_i[16:0] : 17'd0;
        out_last_d  = (p_desc.op == OP_FLUSH);
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            out_valid_q <= 1'b0;
            out_limb_q  <= '0;
            out_last_q  <= 1'b0;
            for (int i = 0; i <= P_STAGE; i++) begin
                pipe_q[i] <= '{op: OP_NONE, t: 17'd0};
            end
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            out_valid_q <= out_valid_d;
            out_limb_q  <= out_limb_d;
            out_last_q  <= out_last_d;
            for (int i = 0; i <= P_STAGE; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign au_a_o      = a_q;
    assign au_b_o      = b_q;
    assign out_valid_o = out_valid_q;
    assign out_limb_o  = out_limb_q;
    assign out_last_o  = out_last_q;

endmodule

// File: tb/tb_pe_au_seq.sv
// Bench for pe_au_seq: a behavioural DSP AU closes the P loop, expected limbs and
// OPMODEs are queued at stimulus time and popped by independent monitors.
module tb_pe_au_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid;
    logic        in_ready_o;
    logic [16:0] in_a, in_b, in_t;
    logic        in_last;
    logic [16:0] au_a_o, au_b_o;
    logic [33:0] au_c_o;
    logic        au_creg_en_o;
    logic [8:0]  au_opmode_o;
    logic [33:0] au_p_i;
    logic        out_valid_o;
    logic [16:0] out_limb_o;
    logic        out_last_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [17:0] exp_q[$];
    logic [8:0]  exp_op_q[$];
    int          out_cyc_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pe_au_seq #(.ABREG(1), .MREG(1)) dut (
        .clock_i      (clk),
        .reset_n_i    (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready_o),
        .in_a_i       (in_a),
        .in_b_i       (in_b),
        .in_t_i       (in_t),
        .in_last_i    (in_last),
        .au_a_o       (au_a_o),
        .au_b_o       (au_b_o),
        .au_c_o       (au_c_o),
        .au_creg_en_o (au_creg_en_o),
        .au_opmode_o  (au_opmode_o),
        .au_p_i       (au_p_i),
        .out_valid_o  (out_valid_o),
        .out_limb_o   (out_limb_o),
        .out_last_o   (out_last_o)
    );

    // DSP model: AREG/BREG, MREG, OPMODE/CREG register, then PREG with P>>17 feedback.
    logic [16:0] m_a = '0, m_b = '0;
    logic [33:0] m_m = '0, m_c = '0, m_p = '0;
    logic [8:0]  m_op = '0;

    always @(posedge clk) begin
        m_a  <= au_a_o;
        m_b  <= au_b_o;
        m_m  <= {17'b0, m_a} * {17'b0, m_b};
        m_op <= au_opmode_o;
        if (au_creg_en_o) m_c <= au_c_o;
        case (m_op)
            9'h035:  m_p <= m_m + m_c;
            9'h1D5:  m_p <= m_m + m_c + (m_p >> 17);
            9'h050:  m_p <= m_p >> 17;
            9'h020:  m_p <= m_p;
            default: m_p <= '0;
        endcase
    end
    assign au_p_i = m_p;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Output monitor
    always @(negedge clk) begin
        if (rst_n && out_valid_o) begin
            out_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL out_unexpected: got limb 0x%0h last %0b, expected no output",
                         out_limb_o, out_last_o);
            end else begin
                check("out_limb", {46'b0, out_last_o, out_limb_o}, {46'b0, exp_q.pop_front()});
            end
        end
    end

    // OPMODE monitor
    always @(negedge clk) begin
        if (rst_n && au_opmode_o != 9'h000) begin
            if (exp_op_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL op_unexpected: got opmode 0x%0h, expected idle", au_opmode_o);
            end else begin
                check("opmode", {55'b0, au_opmode_o}, {55'b0, exp_op_q.pop_front()});
            end
            check("creg_en", {63'b0, au_creg_en_o},
                  {63'b0, (au_opmode_o == 9'h035) || (au_opmode_o == 9'h1D5)});
            check("c_upper", {47'b0, au_c_o[33:17]}, 64'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (8) step();
    endtask

    task automatic send(input logic [16:0] a, input logic [16:0] b,
                        input logic [16:0] t, input logic last);
        int n;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_t     = t;
        in_last  = last;
        n = 0;
        @(negedge clk);
        while (!in_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_o) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: got in_ready 0 for 20 cycles, expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_t     = '0;
        in_last  = 1'b0;
    endtask

    task automatic push_out(input logic last, input logic [16:0] limb);
        exp_q.push_back({last, limb});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_t     = '0;
        in_last  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {out_valid_o, out_limb_o, out_last_o, au_a_o, au_b_o,
                             au_c_o[16:0], au_creg_en_o, au_opmode_o}, 64'd0);
        rst_n = 1'b1;
        step();
        check("reset_ready", {63'b0, in_ready_o}, 64'd1);
        drain();

        // Timing of a one-limb word: 3*5+7 = 0x16, flush 0
        push_out(1'b0, 17'h00016);
        push_out(1'b1, 17'h00000);
        exp_op_q.push_back(9'h035);
        exp_op_q.push_back(9'h050);
        send(17'd3, 17'd5, 17'd7, 1'b1);
        check("t0_ab", {30'b0, au_a_o, au_b_o}, {30'b0, 17'd3, 17'd5});
        check("t0_ready", {63'b0, in_ready_o}, 64'd0);
        step();
        check("t1_op_c", {21'b0, au_opmode_o, au_c_o}, {21'b0, 9'h035, 34'd7});
        step();
        check("t2_op", {55'b0, au_opmode_o}, {55'b0, 9'h050});
        step();
        check("t3_noout", {63'b0, out_valid_o}, 64'd0);
        step();
        check("t4_out", {45'b0, out_valid_o, out_last_o, out_limb_o}, {45'b0, 2'b10, 17'h16});
        step();
        check("t5_out", {62'b0, out_valid_o, out_last_o}, {62'b0, 2'b11});
        step();
        check("t6_out", {63'b0, out_valid_o}, 64'd0);
        drain();

        // Max one-limb word
        push_out(1'b0, 17'h00000);
        push_out(1'b1, 17'h1FFFF);
        exp_op_q.push_back(9'h035);
        exp_op_q.push_back(9'h050);
        send(17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 1'b1);
        drain();

        // Carry propagation across two limbs
        push_out(1'b0, 17'h1FFFE);
        push_out(1'b0, 17'h00002);
        push_out(1'b1, 17'h00000);
        exp_op_q.push_back(9'h035);
        exp_op_q.push_back(9'h1D5);
        exp_op_q.push_back(9'h050);
        send(17'h1FFFF, 17'h00002, 17'h0, 1'b0);
        send(17'h00001, 17'h00001, 17'h0, 1'b1);
        drain();

        // Same word with a two-cycle input gap
        push_out(1'b0, 17'h1FFFE);
        push_out(1'b0, 17'h00002);
        push_out(1'b1, 17'h00000);
        exp_op_q.push_back(9'h035);
        exp_op_q.push_back(9'h020);
        exp_op_q.push_back(9'h020);
        exp_op_q.push_back(9'h1D5);
        exp_op_q.push_back(9'h050);
        out_cyc_q.delete();
        send(17'h1FFFF, 17'h00002, 17'h0, 1'b0);
        step();
        step();
        send(17'h00001, 17'h00001, 17'h0, 1'b1);
        drain();
        check("bubble_count", 64'(out_cyc_q.size()), 64'd3);
        check("bubble_gap", 64'(out_cyc_q[1] - out_cyc_q[0]), 64'd3);
        check("bubble_flush", 64'(out_cyc_q[2] - out_cyc_q[1]), 64'd1);

        // Back-to-back one-limb words
        push_out(1'b0, 17'd1);
        push_out(1'b1, 17'd0);
        push_out(1'b0, 17'd1);
        push_out(1'b1, 17'd0);
        exp_op_q.push_back(9'h035);
        exp_op_q.push_back(9'h050);
        exp_op_q.push_back(9'h035);
        exp_op_q.push_back(9'h050);
        out_cyc_q.delete();
        send(17'd1, 17'd1, 17'd0, 1'b1);
        check("b2b_ready0", {63'b0, in_ready_o}, 64'd0);
        send(17'd1, 17'd1, 17'd0, 1'b1);
        check("b2b_ready2", {63'b0, in_ready_o}, 64'd0);
        step();
        check("b2b_ready3", {63'b0, in_ready_o}, 64'd1);
        drain();
        check("b2b_spacing", 64'(out_cyc_q[2] - out_cyc_q[0]), 64'd2);

        // Worst-case operands in every limb: P reaches 2^34-1
        push_out(1'b0, 17'h00000);
        push_out(1'b0, 17'h1FFFF);
        push_out(1'b1, 17'h1FFFF);
        exp_op_q.push_back(9'h035);
        exp_op_q.push_back(9'h1D5);
        exp_op_q.push_back(9'h050);
        send(17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 1'b0);
        send(17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 1'b1);
        drain();

        // Reset after the first limb of a three-limb word
        send(17'd5, 17'd5, 17'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outs", {out_valid_o, out_limb_o, out_last_o, au_a_o, au_b_o,
                               au_c_o[16:0], au_creg_en_o, au_opmode_o}, 64'd0);
        repeat (3) step();
        rst_n = 1'b1;
        drain();
        push_out(1'b0, 17'h00105);
        push_out(1'b1, 17'h00000);
        exp_op_q.push_back(9'h035);
        exp_op_q.push_back(9'h050);
        send(17'h10, 17'h10, 17'h5, 1'b1);
        drain();

        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        check("exp_op_q_empty", 64'(exp_op_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
